// File: rtl/uart_i2c_cmd_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_i2c_cmd_sequencer_pkg
//  Description : Shared types and constants for the UART-to-I2C command
//                sequencer: FSM state encoding, status byte codes, the frame
//                sync byte and a length-validity helper.
//  Revision    : 1.0  initial release
// ============================================================================
package uart_i2c_cmd_sequencer_pkg;

    localparam int BYTE_W = 8;
    localparam int LEN_W  = 5;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_HDR      = 3'd1,
        S_LEN      = 3'd2,
        S_DATA     = 3'd3,
        S_I2C_GO   = 3'd4,
        S_I2C_WAIT = 3'd5,
        S_TX_DATA  = 3'd6,
        S_TX_STAT  = 3'd7
    } state_t;

    localparam logic [7:0] ST_OK      = 8'h00;
    localparam logic [7:0] ST_NACK    = 8'h01;
    localparam logic [7:0] ST_BADLEN  = 8'h02;
    localparam logic [7:0] ST_TIMEOUT = 8'h03;

    localparam logic [7:0] SYNC_BYTE  = 8'h53;

    // A frame length must be in 1..max_len.
    function automatic logic bad_len(input logic [7:0] len, input logic [7:0] max_len);
        return (len == 8'd0) || (len > max_len);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_i2c_cmd_buf.sv
`default_nettype none
// ============================================================================
//  Module      : uart_i2c_cmd_buf
//  Description : DEPTH x 8 payload register file, one synchronous write port
//                and one asynchronous read port. Contents are not reset.
//  Ports       : i_clock            clock
//                i_we/i_waddr/i_wdata  write port
//                i_raddr / o_rdata     combinational read port
//  Revision    : 1.0  initial release
// ============================================================================
module uart_i2c_cmd_buf
    import uart_i2c_cmd_sequencer_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic              i_clock,
    input  logic              i_we,
    input  logic [AW-1:0]     i_waddr,
    input  logic [BYTE_W-1:0] i_wdata,
    input  logic [AW-1:0]     i_raddr,
    output logic [BYTE_W-1:0] o_rdata
);

    logic [BYTE_W-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clock) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule
`default_nettype wire

// File: rtl/uart_i2c_cmd_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : uart_i2c_cmd_sequencer
//  Description : Parses framed UART commands (SYNC, {addr,rw}, len, data),
//                launches one I2C transaction per frame, then returns read
//                data and a status byte to the UART transmitter.
//  Ports       : i_clock, i_reset_n        clock, async active-low reset
//                i_rx_data/i_rx_valid      UART receive byte + strobe
//                o_i2c_*                   I2C master command interface
//                i_i2c_*                   I2C master responses
//                o_tx_data/o_tx_start      UART transmit byte + strobe
//                i_tx_busy                 transmitter busy
//                o_rx_overrun              byte dropped while not accepting
//  Revision    : 1.0  initial release
// ============================================================================
module uart_i2c_cmd_sequencer
    import uart_i2c_cmd_sequencer_pkg::*;
#(
    parameter int         MAX_LEN = 16,
    parameter int         TIMEOUT = 1041600,
    parameter logic [7:0] SYNC    = SYNC_BYTE
) (
    input  logic             i_clock,
    input  logic             i_reset_n,
    input  logic [7:0]       i_rx_data,
    input  logic             i_rx_valid,
    output logic             o_i2c_start,
    output logic [6:0]       o_i2c_addr,
    output logic             o_i2c_rw,
    output logic [LEN_W-1:0] o_i2c_len,
    output logic [7:0]       o_i2c_wdata,
    input  logic             i_i2c_wnext,
    input  logic [7:0]       i_i2c_rdata,
    input  logic             i_i2c_rvalid,
    input  logic             i_i2c_done,
    input  logic             i_i2c_nack,
    output logic [7:0]       o_tx_data,
    output logic             o_tx_start,
    input  logic             i_tx_busy,
    output logic             o_rx_overrun
);

    localparam int               AW          = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int               TW          = $clog2(TIMEOUT + 1);
    localparam logic [7:0]       C_MAX_LEN8  = 8'(MAX_LEN);
    localparam logic [LEN_W-1:0] C_MAX_LEN   = LEN_W'(MAX_LEN);
    localparam logic [TW-1:0]    C_TMO_LAST  = TW'(TIMEOUT - 1);

    state_t           r_state,     w_state_nxt;
    logic [6:0]       r_addr,      w_addr_nxt;
    logic             r_rw,        w_rw_nxt;
    logic [LEN_W-1:0] r_len,       w_len_nxt;
    logic [LEN_W-1:0] r_wr_ptr,    w_wr_ptr_nxt;
    logic [LEN_W-1:0] r_rd_ptr,    w_rd_ptr_nxt;
    logic [7:0]       r_status,    w_status_nxt;
    logic [TW-1:0]    r_timer,     w_timer_nxt;
    logic             r_i2c_start, w_i2c_start_nxt;
    logic             r_tx_start,  w_tx_start_nxt;
    logic [7:0]       r_tx_data,   w_tx_data_nxt;
    logic             r_guard,     w_guard_nxt;

    logic             w_buf_we;
    logic [AW-1:0]    w_buf_waddr;
    logic [7:0]       w_buf_wdata;
    logic [7:0]       w_buf_rdata;
    logic             w_timeout;
    logic             w_tx_ok;
    logic [LEN_W-1:0] w_len_last;

    // rd_ptr doubles as the I2C write-data index and the TX_DATA read index.
    uart_i2c_cmd_buf #(
        .DEPTH (MAX_LEN),
        .AW    (AW)
    ) u_buf (
        .i_clock (i_clock),
        .i_we    (w_buf_we),
        .i_waddr (w_buf_waddr),
        .i_wdata (w_buf_wdata),
        .i_raddr (r_rd_ptr[AW-1:0]),
        .o_rdata (w_buf_rdata)
    );

    assign w_timeout  = (r_timer == C_TMO_LAST);
    // The guard skips the cycle in which tx_start is high, since the
    // transmitter may not raise tx_busy until the following cycle.
    assign w_tx_ok    = !i_tx_busy && !r_guard;
    assign w_len_last = r_len - LEN_W'(1);

    always_comb begin
        w_state_nxt     = r_state;
        w_addr_nxt      = r_addr;
        w_rw_nxt        = r_rw;
        w_len_nxt       = r_len;
        w_wr_ptr_nxt    = r_wr_ptr;
        w_rd_ptr_nxt    = r_rd_ptr;
        w_status_nxt    = r_status;
        w_timer_nxt     = '0;
        w_i2c_start_nxt = 1'b0;
        w_tx_start_nxt  = 1'b0;
        w_tx_data_nxt   = r_tx_data;
        w_guard_nxt     = 1'b0;
        w_buf_we        = 1'b0;
        w_buf_waddr     = r_wr_ptr[AW-1:0];
        w_buf_wdata     = i_rx_data;

        case (r_state)
            S_IDLE: begin
                if (i_rx_valid && (i_rx_data == SYNC)) begin
                    w_state_nxt = S_HDR;
                end
            end
            S_HDR: begin
                w_timer_nxt = r_timer + TW'(1);
                if (i_rx_valid) begin
                    w_timer_nxt = '0;
                    w_addr_nxt  = i_rx_data[7:1];
                    w_rw_nxt    = i_rx_data[0];
                    w_state_nxt = S_LEN;
                end else if (w_timeout) begin
                    w_status_nxt = ST_TIMEOUT;
                    w_state_nxt  = S_TX_STAT;
                end
            end
            S_LEN: begin
                w_timer_nxt = r_timer + TW'(1);
                if (i_rx_valid) begin
                    w_timer_nxt  = '0;
                    // Read data also lands from index 0, so clear for both directions.
                    w_wr_ptr_nxt = '0;
                    if (bad_len(i_rx_data, C_MAX_LEN8)) begin
                        w_status_nxt = ST_BADLEN;
                        w_state_nxt  = S_TX_STAT;
                    end else begin
                        w_len_nxt = i_rx_data[LEN_W-1:0];
                        if (r_rw) begin
                            w_i2c_start_nxt = 1'b1;
                            w_state_nxt     = S_I2C_GO;
                        end else begin
                            w_state_nxt = S_DATA;
                        end
                    end
                end else if (w_timeout) begin
                    w_status_nxt = ST_TIMEOUT;
                    w_state_nxt  = S_TX_STAT;
                end
            end
            S_DATA: begin
                w_timer_nxt = r_timer + TW'(1);
                if (i_rx_valid) begin
                    w_timer_nxt  = '0;
                    w_buf_we     = 1'b1;
                    w_wr_ptr_nxt = r_wr_ptr + LEN_W'(1);
                    if (r_wr_ptr == w_len_last) begin
                        w_i2c_start_nxt = 1'b1;
                        w_state_nxt     = S_I2C_GO;
                    end
                end else if (w_timeout) begin
                    w_status_nxt = ST_TIMEOUT;
                    w_state_nxt  = S_TX_STAT;
                end
            end
            S_I2C_GO: begin
                w_rd_ptr_nxt = '0;
                w_state_nxt  = S_I2C_WAIT;
            end
            S_I2C_WAIT: begin
                if (i_i2c_wnext && (r_rd_ptr != w_len_last)) begin
                    w_rd_ptr_nxt = r_rd_ptr + LEN_W'(1);
                end
                if (i_i2c_rvalid && (r_wr_ptr < C_MAX_LEN)) begin
                    w_buf_we     = 1'b1;
                    w_buf_wdata  = i_i2c_rdata;
                    w_wr_ptr_nxt = r_wr_ptr + LEN_W'(1);
                end
                if (i_i2c_done) begin
                    if (i_i2c_nack) begin
                        w_status_nxt = ST_NACK;
                        w_state_nxt  = S_TX_STAT;
                    end else begin
                        w_status_nxt = ST_OK;
                        if (r_rw) begin
                            w_rd_ptr_nxt = '0;
                            w_state_nxt  = S_TX_DATA;
                        end else begin
                            w_state_nxt = S_TX_STAT;
                        end
                    end
                end
            end
            S_TX_DATA: begin
                if (w_tx_ok) begin
                    w_tx_start_nxt = 1'b1;
                    w_tx_data_nxt  = w_buf_rdata;
                    w_guard_nxt    = 1'b1;
                    if (r_rd_ptr == w_len_last) begin
                        w_state_nxt = S_TX_STAT;
                    end else begin
                        w_rd_ptr_nxt = r_rd_ptr + LEN_W'(1);
                    end
                end
            end
            S_TX_STAT: begin
                if (w_tx_ok) begin
                    w_tx_start_nxt = 1'b1;
                    w_tx_data_nxt  = r_status;
                    w_guard_nxt    = 1'b1;
                    w_state_nxt    = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_rw        <= 1'b0;
            r_len       <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_status    <= '0;
            r_timer     <= '0;
            r_i2c_start <= 1'b0;
            r_tx_start  <= 1'b0;
            r_tx_data   <= '0;
            r_guard     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_addr      <= w_addr_nxt;
            r_rw        <= w_rw_nxt;
            r_len       <= w_len_nxt;
            r_wr_ptr    <= w_wr_ptr_nxt;
            r_rd_ptr    <= w_rd_ptr_nxt;
            r_status    <= w_status_nxt;
            r_timer     <= w_timer_nxt;
            r_i2c_start <= w_i2c_start_nxt;
            r_tx_start  <= w_tx_start_nxt;
            r_tx_data   <= w_tx_data_nxt;
            r_guard     <= w_guard_nxt;
        end
    end

    assign o_i2c_start  = r_i2c_start;
    assign o_i2c_addr   = r_addr;
    assign o_i2c_rw     = r_rw;
    assign o_i2c_len    = r_len;
    // Buffer contents are not reset, so only expose them while the master uses them.
    assign o_i2c_wdata  = (r_state == S_I2C_WAIT) ? w_buf_rdata : 8'h00;
    assign o_tx_data    = r_tx_data;
    assign o_tx_start   = r_tx_start;
    assign o_rx_overrun = i_rx_valid && ((r_state == S_I2C_GO)  || (r_state == S_I2C_WAIT) ||
                                         (r_state == S_TX_DATA) || (r_state == S_TX_STAT));

endmodule
`default_nettype wire

// File: tb/tb_uart_i2c_cmd_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_i2c_cmd_sequencer
//  Description : Directed, table-driven bench for uart_i2c_cmd_sequencer with
//                a small I2C master stand-in and a UART transmitter model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_uart_i2c_cmd_sequencer;

    localparam int MAX_LEN = 16;
    localparam int TIMEOUT = 64;
    localparam int NVEC    = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] rx_data = '0;
    logic       rx_valid = 1'b0;
    logic       i2c_start;
    logic [6:0] i2c_addr;
    logic       i2c_rw;
    logic [4:0] i2c_len;
    logic [7:0] i2c_wdata;
    logic       i2c_wnext = 1'b0;
    logic [7:0] i2c_rdata = '0;
    logic       i2c_rvalid = 1'b0;
    logic       i2c_done = 1'b0;
    logic       i2c_nack = 1'b0;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_busy = 1'b0;
    logic       rx_overrun;

    always #5 clk = ~clk;

    uart_i2c_cmd_sequencer #(
        .MAX_LEN (MAX_LEN),
        .TIMEOUT (TIMEOUT),
        .SYNC    (8'h53)
    ) dut (
        .i_clock      (clk),
        .i_reset_n    (rst_n),
        .i_rx_data    (rx_data),
        .i_rx_valid   (rx_valid),
        .o_i2c_start  (i2c_start),
        .o_i2c_addr   (i2c_addr),
        .o_i2c_rw     (i2c_rw),
        .o_i2c_len    (i2c_len),
        .o_i2c_wdata  (i2c_wdata),
        .i_i2c_wnext  (i2c_wnext),
        .i_i2c_rdata  (i2c_rdata),
        .i_i2c_rvalid (i2c_rvalid),
        .i_i2c_done   (i2c_done),
        .i_i2c_nack   (i2c_nack),
        .o_tx_data    (tx_data),
        .o_tx_start   (tx_start),
        .i_tx_busy    (tx_busy),
        .o_rx_overrun (rx_overrun)
    );

    // Byte arrays are packed with element [0] = first byte, so the
    // concatenations below list bytes last-first.
    typedef struct {
        int               nrx;
        logic [19:0][7:0] rx;
        bit               start;
        logic [6:0]       addr;
        bit               rw;
        logic [4:0]       len;
        int               nrd;
        logic [15:0][7:0] rd;
        bit               rd_with_done;
        bit               nack;
        int               ntx;
        logic [16:0][7:0] tx;
    } vec_t;

    vec_t       vecs[NVEC];
    int         n_vec = 0;
    int         n_err = 0;
    int         n_start = 0;
    int         n_busy_viol = 0;
    int         busy_cnt = 0;
    logic [7:0] tx_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // UART transmitter model: busy for 5 cycles after each accepted byte.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                busy_cnt = 0;
                tx_busy  = 1'b0;
            end else if (tx_start) begin
                if (tx_busy) n_busy_viol++;
                tx_q.push_back(tx_data);
                busy_cnt = 5;
                tx_busy  = 1'b1;
            end else if (busy_cnt > 0) begin
                busy_cnt--;
                if (busy_cnt == 0) tx_busy = 1'b0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (i2c_start) n_start++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        n_err++;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    task automatic send_rx(input logic [7:0] b, input logic exp_ovr);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        #1;
        check($sformatf("overrun on rx %0h", b), 32'(rx_overrun), 32'(exp_ovr));
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic wait_tx(input int n, input int budget);
        int cyc = 0;
        while (tx_q.size() < n && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        if (tx_q.size() < n)
            check("tx wait expired", 32'(tx_q.size()), 32'(n));
    endtask

    task automatic pulse_done(input logic nack);
        i2c_done = 1'b1;
        i2c_nack = nack;
        @(negedge clk);
        i2c_done = 1'b0;
        i2c_nack = 1'b0;
    endtask

    task automatic run_vec(input int idx);
        vec_t v;
        int   k;
        v = vecs[idx];
        tx_q.delete();
        n_start     = 0;
        n_busy_viol = 0;
        for (int i = 0; i < v.nrx; i++) send_rx(v.rx[i], 1'b0);
        if (v.start) begin
            check($sformatf("v%0d start latency", idx), 32'(i2c_start), 32'd1);
            check($sformatf("v%0d addr", idx), 32'(i2c_addr), 32'(v.addr));
            check($sformatf("v%0d rw", idx), 32'(i2c_rw), 32'(v.rw));
            check($sformatf("v%0d len", idx), 32'(i2c_len), 32'(v.len));
            @(negedge clk);
            if (!v.rw) begin
                // One extra wnext beyond len shows the pointer saturating.
                for (int j = 0; j <= int'(v.len); j++) begin
                    k = (j < int'(v.len)) ? j : int'(v.len) - 1;
                    check($sformatf("v%0d wdata%0d", idx, j), 32'(i2c_wdata),
                          32'(v.rx[v.nrx - int'(v.len) + k]));
                    i2c_wnext = 1'b1;
                    @(negedge clk);
                    i2c_wnext = 1'b0;
                end
            end
            for (int j = 0; j < v.nrd; j++) begin
                i2c_rdata  = v.rd[j];
                i2c_rvalid = 1'b1;
                if (j == v.nrd - 1 && v.rd_with_done) begin
                    i2c_done = 1'b1;
                    i2c_nack = v.nack;
                end
                @(negedge clk);
                i2c_rvalid = 1'b0;
                i2c_done   = 1'b0;
                i2c_nack   = 1'b0;
            end
            if (!(v.nrd > 0 && v.rd_with_done)) pulse_done(v.nack);
        end
        wait_tx(v.ntx, 400);
        repeat (20) @(negedge clk);
        check($sformatf("v%0d tx count", idx), 32'(tx_q.size()), 32'(v.ntx));
        for (int i = 0; i < v.ntx; i++)
            if (i < tx_q.size())
                check($sformatf("v%0d tx%0d", idx, i), 32'(tx_q[i]), 32'(v.tx[i]));
        check($sformatf("v%0d start count", idx), 32'(n_start), 32'(v.start));
        check($sformatf("v%0d tx while busy", idx), 32'(n_busy_viol), 32'd0);
    endtask

    initial begin
        int k;
        for (int i = 0; i < NVEC; i++) begin
            vecs[i].nrx = 0; vecs[i].rx = '0; vecs[i].start = 1'b0; vecs[i].addr = '0;
            vecs[i].rw = 1'b0; vecs[i].len = '0; vecs[i].nrd = 0; vecs[i].rd = '0;
            vecs[i].rd_with_done = 1'b0; vecs[i].nack = 1'b0; vecs[i].ntx = 0; vecs[i].tx = '0;
        end
        // write 2 bytes to 0x50, ACK
        vecs[0].nrx = 5; vecs[0].rx = 160'({8'h22, 8'h11, 8'h02, 8'hA0, 8'h53});
        vecs[0].start = 1; vecs[0].addr = 7'h50; vecs[0].rw = 0; vecs[0].len = 5'd2;
        vecs[0].ntx = 1; vecs[0].tx = 136'(8'h00);
        // read 3 bytes; last byte arrives together with done
        vecs[1].nrx = 3; vecs[1].rx = 160'({8'h03, 8'hA1, 8'h53});
        vecs[1].start = 1; vecs[1].addr = 7'h50; vecs[1].rw = 1; vecs[1].len = 5'd3;
        vecs[1].nrd = 3; vecs[1].rd = 128'({8'hCC, 8'hBB, 8'hAA}); vecs[1].rd_with_done = 1;
        vecs[1].ntx = 4; vecs[1].tx = 136'({8'h00, 8'hCC, 8'hBB, 8'hAA});
        // write NACKed
        vecs[2].nrx = 4; vecs[2].rx = 160'({8'h5A, 8'h01, 8'hA4, 8'h53});
        vecs[2].start = 1; vecs[2].addr = 7'h52; vecs[2].rw = 0; vecs[2].len = 5'd1;
        vecs[2].nack = 1; vecs[2].ntx = 1; vecs[2].tx = 136'(8'h01);
        // len 0 and len 17 are rejected
        vecs[3].nrx = 3; vecs[3].rx = 160'({8'h00, 8'hA0, 8'h53});
        vecs[3].ntx = 1; vecs[3].tx = 136'(8'h02);
        vecs[4].nrx = 3; vecs[4].rx = 160'({8'h11, 8'hA0, 8'h53});
        vecs[4].ntx = 1; vecs[4].tx = 136'(8'h02);
        // garbage before SYNC, then 1-byte read
        vecs[5].nrx = 5; vecs[5].rx = 160'({8'h01, 8'hA1, 8'h53, 8'hFF, 8'h00});
        vecs[5].start = 1; vecs[5].addr = 7'h50; vecs[5].rw = 1; vecs[5].len = 5'd1;
        vecs[5].nrd = 1; vecs[5].rd = 128'(8'h7E);
        vecs[5].ntx = 2; vecs[5].tx = 136'({8'h00, 8'h7E});
        // read NACKed: status only
        vecs[6].nrx = 3; vecs[6].rx = 160'({8'h02, 8'hA3, 8'h53});
        vecs[6].start = 1; vecs[6].addr = 7'h51; vecs[6].rw = 1; vecs[6].len = 5'd2;
        vecs[6].nack = 1; vecs[6].ntx = 1; vecs[6].tx = 136'(8'h01);
        // maximum-length write to 0x54
        vecs[7].nrx = 19; vecs[7].rx[0] = 8'h53; vecs[7].rx[1] = 8'hA8; vecs[7].rx[2] = 8'h10;
        for (int j = 0; j < 16; j++) vecs[7].rx[3 + j] = 8'(8'h30 + j);
        vecs[7].start = 1; vecs[7].addr = 7'h54; vecs[7].rw = 0; vecs[7].len = 5'd16;
        vecs[7].ntx = 1; vecs[7].tx = 136'(8'h00);

        // reset state
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset i2c_start", 32'(i2c_start), 32'd0);
        check("reset tx_start", 32'(tx_start), 32'd0);
        check("reset outs", 32'({i2c_addr, i2c_rw, i2c_len, i2c_wdata, tx_data}), 32'd0);
        check("reset overrun", 32'(rx_overrun), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < NVEC; i++) run_vec(i);

        // timeout after the header byte, then a normal frame
        tx_q.delete();
        n_start = 0;
        send_rx(8'h53, 1'b0);
        send_rx(8'hA0, 1'b0);
        k = 0;
        while (!tx_start && k < TIMEOUT + 50) begin
            @(negedge clk);
            k++;
        end
        check("timeout latency", 32'(k), 32'(TIMEOUT + 1));
        wait_tx(1, 50);
        repeat (10) @(negedge clk);
        check("timeout tx count", 32'(tx_q.size()), 32'd1);
        if (tx_q.size() > 0) check("timeout status", 32'(tx_q[0]), 32'h03);
        check("timeout no start", 32'(n_start), 32'd0);
        run_vec(0);

        // rx byte during I2C_WAIT: overrun pulse, transaction unaffected
        tx_q.delete();
        send_rx(8'h53, 1'b0);
        send_rx(8'hA2, 1'b0);
        send_rx(8'h01, 1'b0);
        send_rx(8'h99, 1'b0);
        check("ovr start", 32'(i2c_start), 32'd1);
        @(negedge clk);
        send_rx(8'h53, 1'b1);
        check("ovr wdata", 32'(i2c_wdata), 32'h99);
        pulse_done(1'b0);
        wait_tx(1, 100);
        repeat (10) @(negedge clk);
        check("ovr tx count", 32'(tx_q.size()), 32'd1);
        if (tx_q.size() > 0) check("ovr status", 32'(tx_q[0]), 32'h00);

        // reset during I2C_WAIT: outputs clear at once, no status byte
        tx_q.delete();
        n_start = 0;
        send_rx(8'h53, 1'b0);
        send_rx(8'hA0, 1'b0);
        send_rx(8'h01, 1'b0);
        send_rx(8'h77, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst wait start", 32'(i2c_start), 32'd0);
        check("rst wait outs", 32'({i2c_addr, i2c_rw, i2c_len, i2c_wdata, tx_data}), 32'd0);
        check("rst wait tx_start", 32'(tx_start), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        pulse_done(1'b0);
        repeat (30) @(negedge clk);
        check("rst wait no tx", 32'(tx_q.size()), 32'd0);
        run_vec(1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
